// File: rtl/muller_c_seq_ctrl.sv
// muller_c_seq_ctrl: drives the A/B inputs of a Muller C-element through a
// programmed number of 4-phase handshakes. The element output is sampled
// through a synchronizer, and each handshake is graded on hold behaviour and
// on completion. Pass/fail counts and a sticky abort flag are reported.
module muller_c_seq_ctrl #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             c_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err
);

  localparam int TMR_MAX = (HOLD_CYC > TIMEOUT) ? HOLD_CYC : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_UP, WAIT_HI, LEAD_DN, WAIT_LO, RECOVER, FIN
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   c_sync;
  logic [1:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]       pass_q, pass_d;
  logic [CNT_W-1:0]       fail_q, fail_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   a_q, a_d, b_q, b_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   err_q, err_d, viol_q, viol_d;
  logic                   sim;
  logic                   complete, hs_fail;

  // Saturating increment for the result counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // {a,b} after the leading edge of the rising phase; its complement gives
  // the inputs after the leading edge of the falling phase.
  function automatic logic [1:0] lead_up(input logic [1:0] m);
    case (m)
      2'b01:   lead_up = 2'b10;
      2'b10:   lead_up = 2'b01;
      default: lead_up = 2'b11;
    endcase
  endfunction

  assign c_sync = sync_q[SYNC_STAGES-1];
  assign sim    = (mode_q == 2'b00) || (mode_q == 2'b11);

  // Synchronizer for the asynchronous C-element output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], c_in};
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      rem_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      tmr_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      viol_q  <= viol_d;
    end
  end

  // Next-state logic: handshake sequencing, grading and counting.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q + TMR_W'(1);
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    viol_d   = viol_q;
    complete = 1'b0;
    hs_fail  = viol_q;

    case (state_q)
      IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        // A start coinciding with the done pulse belongs to the old run.
        if (start && !done_q) begin
          mode_d = mode;
          rem_d  = num_cycles;
          pass_d = '0;
          fail_d = '0;
          err_d  = 1'b0;
          viol_d = 1'b0;
          busy_d = 1'b1;
          tmr_d  = '0;
          if (num_cycles == '0) begin
            state_d = FIN;
          end else begin
            state_d    = LEAD_UP;
            {a_d, b_d} = lead_up(mode);
          end
        end
      end
      LEAD_UP: begin
        if (sim) begin
          state_d = WAIT_HI;
          tmr_d   = '0;
        end else begin
          if (c_sync) viol_d = 1'b1;
          if (tmr_q == TMR_W'(HOLD_CYC - 1)) begin
            a_d     = 1'b1;
            b_d     = 1'b1;
            state_d = WAIT_HI;
            tmr_d   = '0;
          end
        end
      end
      WAIT_HI: begin
        if (c_sync) begin
          {a_d, b_d} = ~lead_up(mode_q);
          state_d    = LEAD_DN;
          tmr_d      = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          viol_d  = 1'b1;
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = RECOVER;
          tmr_d   = '0;
        end
      end
      LEAD_DN: begin
        if (sim) begin
          state_d = WAIT_LO;
          tmr_d   = '0;
        end else begin
          if (!c_sync) viol_d = 1'b1;
          if (tmr_q == TMR_W'(HOLD_CYC - 1)) begin
            a_d     = 1'b0;
            b_d     = 1'b0;
            state_d = WAIT_LO;
            tmr_d   = '0;
          end
        end
      end
      WAIT_LO: begin
        if (!c_sync) begin
          complete = 1'b1;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          viol_d  = 1'b1;
          state_d = RECOVER;
          tmr_d   = '0;
        end
      end
      RECOVER: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (!c_sync) begin
          complete = 1'b1;
          hs_fail  = 1'b1;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          // Element never returned low: abort the whole run.
          err_d   = 1'b1;
          fail_d  = sat_inc(fail_q);
          state_d = FIN;
        end
      end
      FIN: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // One count per handshake, then either the next handshake or the end.
    if (complete) begin
      if (hs_fail) fail_d = sat_inc(fail_q);
      else         pass_d = sat_inc(pass_q);
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        state_d = FIN;
      end else begin
        state_d    = LEAD_UP;
        {a_d, b_d} = lead_up(mode_q);
        viol_d     = 1'b0;
        tmr_d      = '0;
      end
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign err      = err_q;

endmodule

// File: doc/muller_c_seq_ctrl.md
Name: muller_c_seq_ctrl

Overview:
Synchronous sequencer that exercises the Muller C-element in the muller_c_proj user area. It drives the element's two inputs A and B through a programmed number of 4-phase handshakes, and samples the element's asynchronous output through a synchronizer. For each handshake it checks hold behaviour and the completion edge, and counts results. It replaces manual io_in toggling for on-chip self-test, and its status is readable by the wrapper logic.

Parameters:
CNT_W, 8, width of num_cycles, pass_cnt and fail_cnt
SYNC_STAGES, 2, flops in the c_in synchronizer (minimum 2)
HOLD_CYC, 4, cycles one input is held alone before the second moves (must be > SYNC_STAGES)
TIMEOUT, 16, max cycles to wait for the synchronized output to reach its target

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a run; ignored while busy
mode  in  2  00 simultaneous, 01 A leads, 10 B leads, 11 treated as 00
num_cycles  in  CNT_W  handshakes to run; sampled on accepted start
c_in  in  1  raw C-element output (asynchronous)
a_out  out  1  C-element input A
b_out  out  1  C-element input B
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of run
pass_cnt  out  CNT_W  handshakes passed, saturating
fail_cnt  out  CNT_W  handshakes failed, saturating
err  out  1  sticky abort flag: element stuck, run aborted

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, synchronizer cleared. A mid-run reset forces a_out/b_out low immediately.
- c_sync is c_in after SYNC_STAGES flops. All checks use c_sync only.
- States are IDLE, LEAD_UP, WAIT_HI, LEAD_DN, WAIT_LO, RECOVER, FIN.
- IDLE, start=1:
  - Latch mode and num_cycles.
  - Clear pass_cnt, fail_cnt and err.
  - Set busy the next cycle.
  - If num_cycles=0, go to FIN, so done pulses 2 cycles after start.
  - Otherwise go to LEAD_UP.
- LEAD_UP:
  - mode 00: a_out and b_out rise together on entry, then go straight to WAIT_HI.
  - mode 01: a_out rises alone; mode 10: b_out rises alone. Hold HOLD_CYC cycles.
  - Any cycle with c_sync=1 during the hold marks the current handshake a hold violation.
  - After the hold, raise the other input and enter WAIT_HI.
- WAIT_HI: wait for c_sync=1.
  - Reached within TIMEOUT cycles: enter LEAD_DN.
  - Not reached: mark the handshake failed, drive both inputs low, enter RECOVER.
- LEAD_DN: mirror of LEAD_UP with inputs falling. Leading input is per mode; hold violation is c_sync=0 during the hold.
- WAIT_LO: wait for c_sync=0.
  - Reached within TIMEOUT cycles: the handshake completes.
  - Not reached: mark the handshake failed, enter RECOVER.
- Handshake completion:
  - Increment pass_cnt if no violation was flagged, else fail_cnt; one increment per handshake.
  - Decrement the remaining count. If zero go to FIN, else go to LEAD_UP the next cycle.
- RECOVER:
  - Both inputs low; wait up to TIMEOUT cycles for c_sync=0.
  - Reached: count the handshake as failed and continue as on completion.
  - Not reached: set err, count the failure, go to FIN (abort).
- FIN: a_out=b_out=0, done=1 for exactly one cycle, busy drops in the same cycle, return to IDLE.
- Counter rules:
  - Counters saturate at all-ones.
  - Counters and err hold their values after done, until the next accepted start.
- Boundary cases:
  - start while busy: no effect.
  - start in the same cycle as done: ignored. A new start is accepted from the cycle after done.
  - c_in glitching between samples is irrelevant; only synchronized values are checked.

Test Plan:
- Ideal C-element model (1-cycle delay), mode 00, num_cycles=3 -> 3 full handshakes on a_out/b_out, pass_cnt=3, fail_cnt=0, err=0, one done pulse.
- Ideal model, mode 01, num_cycles=2 -> a_out leads b_out by HOLD_CYC=4 cycles on both edges, pass_cnt=2.
- Model replaced by an OR gate, mode 10, num_cycles=2 -> hold violations, fail_cnt=2, pass_cnt=0, err=0.
- c_in stuck at 1, num_cycles=5 -> WAIT_HI passes, WAIT_LO times out, RECOVER times out; err=1, fail_cnt=1, done after abort.
- c_in stuck at 0, num_cycles=2 -> WAIT_HI times out twice, fail_cnt=2, err=0. Then num_cycles=0 -> done 2 cycles after start with all counts 0.
- rst_n asserted mid-WAIT_HI -> a_out/b_out/busy drop immediately, counters 0. A start 2 cycles after release runs normally. A start pulsed while busy is ignored.
